// File: rtl/bcd_scan_counter.sv
// NDIG-digit BCD up/down counter with a time-multiplexed digit scanner
// that feeds a 7-segment decoder and drives a one-hot digit-enable bus.
module bcd_scan_counter #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic              blank_lz,
  input  logic [4*NDIG-1:0] load_val,
  output logic [4*NDIG-1:0] cnt_bcd,
  output logic              carry,
  output logic [3:0]        bcd,
  output logic [NDIG-1:0]   dig_sel
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);

  logic [4*NDIG-1:0] r_cnt;
  logic              r_carry;
  logic [PW-1:0]     r_pre;
  logic [IW-1:0]     r_idx;
  logic [3:0]        r_bcd;
  logic [NDIG-1:0]   r_dig_sel;

  logic [4*NDIG-1:0] w_cnt_nxt;
  logic              w_wrap;
  logic              w_rip;
  logic [3:0]        w_nib;
  logic [NDIG-1:0]   w_lz;
  logic [3:0]        w_dig;
  logic              w_blank;
  logic [3:0]        w_scan;
  logic              w_pre_wrap;

  // Next count: sanitised load, or a rippling BCD increment/decrement.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_wrap    = 1'b0;
    w_rip     = 1'b0;
    w_nib     = 4'd0;
    if (load) begin
      for (int i = 0; i < NDIG; i++) begin
        w_nib = load_val[4*i +: 4];
        w_cnt_nxt[4*i +: 4] = (w_nib > 4'd9) ? 4'd0 : w_nib;
      end
    end else if (en) begin
      w_rip = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
        w_nib = r_cnt[4*i +: 4];
        if (w_rip) begin
          if (up) begin
            if (w_nib == 4'd9) begin
              w_cnt_nxt[4*i +: 4] = 4'd0;
            end else begin
              w_cnt_nxt[4*i +: 4] = w_nib + 4'd1;
              w_rip = 1'b0;
            end
          end else begin
            if (w_nib == 4'd0) begin
              w_cnt_nxt[4*i +: 4] = 4'd9;
            end else begin
              w_cnt_nxt[4*i +: 4] = w_nib - 4'd1;
              w_rip = 1'b0;
            end
          end
        end else begin
          w_cnt_nxt[4*i +: 4] = w_nib;
        end
      end
      w_wrap = w_rip;
    end else begin
      w_wrap = 1'b0;
    end
  end

  // w_lz[i] is set when digits i..NDIG-1 are all zero.
  always_comb begin
    w_lz = '0;
    w_lz[NDIG-1] = (r_cnt[4*NDIG-1 -: 4] == 4'd0);
    for (int i = NDIG - 2; i >= 0; i--) begin
      w_lz[i] = w_lz[i+1] & (r_cnt[4*i +: 4] == 4'd0);
    end
  end

  assign w_dig      = r_cnt[{r_idx, 2'b00} +: 4];
  assign w_blank    = blank_lz && (r_idx != IW'(0)) && w_lz[r_idx];
  assign w_scan     = w_blank ? 4'hF : w_dig;
  assign w_pre_wrap = (r_pre == PW'(SCAN_DIV - 1));

  // Counter state and registered wrap pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_carry <= w_wrap;
    end
  end

  // Free-running prescaler and scan index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_pre_wrap) begin
      r_pre <= '0;
      r_idx <= (r_idx == IW'(NDIG - 1)) ? IW'(0) : r_idx + IW'(1);
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Scanned outputs, both updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd     <= 4'h0;
      r_dig_sel <= NDIG'(1);
    end else begin
      r_bcd     <= w_scan;
      r_dig_sel <= NDIG'(1) << r_idx;
    end
  end

  assign cnt_bcd = r_cnt;
  assign carry   = r_carry;
  assign bcd     = r_bcd;
  assign dig_sel = r_dig_sel;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed + randomized bench for bcd_scan_counter against an arithmetic
// reference model (count kept as an integer, display derived from it).
module tb_bcd_scan_counter;

  localparam int NDIG = 4;
  localparam int SD   = 4;
  localparam int MODV = 10000;

  logic              clk, rst, en, up, load, blank_lz;
  logic [4*NDIG-1:0] load_val;
  logic [4*NDIG-1:0] cnt_bcd;
  logic              carry;
  logic [3:0]        bcd;
  logic [NDIG-1:0]   dig_sel;

  int n_cmp = 0;
  int n_err = 0;
  int n_edge;
  int m_val;
  int m_carry;

  bcd_scan_counter #(.NDIG(NDIG), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .blank_lz(blank_lz),
    .load_val(load_val), .cnt_bcd(cnt_bcd), .carry(carry), .bcd(bcd), .dig_sel(dig_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*NDIG-1:0] to_bcd(input int v);
    logic [4*NDIG-1:0] r = '0;
    for (int k = 0; k < NDIG; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic int sanitize(input logic [4*NDIG-1:0] lv);
    int r = 0;
    int nib;
    for (int k = 0; k < NDIG; k++) begin
      nib = int'(lv[4*k +: 4]);
      r = r + ((nib > 9) ? 0 : nib) * pow10(k);
    end
    return r;
  endfunction

  function automatic logic [3:0] shown(input int v, input int pos, input logic blank);
    if (blank && pos > 0 && v < pow10(pos)) return 4'hF;
    return 4'((v / pow10(pos)) % 10);
  endfunction

  // One clock edge: advance the model with the inputs sampled there, then compare.
  task automatic tick();
    int prev_val;
    int prev_idx;
    logic [3:0] exp_bcd;
    @(posedge clk);
    #1;
    prev_val = m_val;
    prev_idx = (n_edge / SD) % NDIG;
    exp_bcd  = shown(prev_val, prev_idx, blank_lz);
    n_edge++;
    if (load) begin
      m_val = sanitize(load_val);
      m_carry = 0;
    end else if (en) begin
      if (up) begin
        m_carry = (m_val == MODV - 1) ? 1 : 0;
        m_val = (m_val + 1) % MODV;
      end else begin
        m_carry = (m_val == 0) ? 1 : 0;
        m_val = (m_val + MODV - 1) % MODV;
      end
    end else begin
      m_carry = 0;
    end
    check("cnt_bcd", 32'(cnt_bcd), 32'(to_bcd(m_val)));
    check("carry", 32'(carry), 32'(m_carry));
    check("dig_sel", 32'(dig_sel), 32'(1 << prev_idx));
    check("bcd", 32'(bcd), 32'(exp_bcd));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cnt"}, 32'(cnt_bcd), 32'd0);
    check({tag, "_carry"}, 32'(carry), 32'd0);
    check({tag, "_dig_sel"}, 32'(dig_sel), 32'd1);
    check({tag, "_bcd"}, 32'(bcd), 32'd0);
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic b,
                       input logic [4*NDIG-1:0] lv);
    en = e; up = u; load = l; blank_lz = b; load_val = lv;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    // T1: asynchronous reset, checked before any clock edge
    #2;
    check_reset_state("t1_reset");
    n_edge = 0; m_val = 0; m_carry = 0;
    #6;
    rst = 1'b0;
    tick();

    // T2: up wrap
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h9998); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000); tick(); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000); tick();

    // T3: down borrow ripple and down wrap
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h1000); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000); tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000); tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000); tick();

    // T4: load wins over en, illegal nibbles load as zero
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h3A7F); tick();
    check("t4_sanitised", 32'(cnt_bcd), 32'h3070);

    // T5: scan of a static 1234 over two frames
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h1234); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < 2 * NDIG * SD + 3; k++) tick();

    // T6: leading-zero blanking
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0042); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    for (int k = 0; k < NDIG * SD + 2; k++) tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    for (int k = 0; k < NDIG * SD + 2; k++) tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0042); tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int k = 0; k < NDIG * SD + 2; k++) tick();

    // Randomized traffic, including near-wrap loads
    for (int k = 0; k < 400; k++) begin
      logic [4*NDIG-1:0] lv;
      lv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) lv = ($urandom_range(0, 1) == 1) ? 16'h9997 : 16'h0002;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 15) == 0),
            1'($urandom), lv);
      tick();
    end

    // Mid-operation reset, away from any clock edge
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h5678); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("midop_reset");
    n_edge = 0; m_val = 0; m_carry = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
